// File: rtl/bus_control_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : bus_control_sequencer_if                                 |
// | Description : Instruction-in / control-out bundle of the bus control   |
// |               sequencer. master = sequencer, slave = its environment.  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
interface bus_control_sequencer_if #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
);
  logic                 run;
  logic [3+2*IDX_W-1:0] din;
  logic [IDX_W-1:0]     reg_index;
  logic                 reg_en;
  logic [IDX_W-1:0]     tri_index;
  logic                 tri_en;
  logic                 din_out;
  logic                 ir_in;
  logic                 a_in;
  logic                 g_in;
  logic                 g_out;
  logic                 add_sub;
  logic                 done;
  logic                 illegal;
  logic                 busy;
  logic [CNT_W-1:0]     instr_count;

  modport master (
    input  run, din,
    output reg_index, reg_en, tri_index, tri_en, din_out, ir_in, a_in,
           g_in, g_out, add_sub, done, illegal, busy, instr_count
  );

  modport slave (
    output run, din,
    input  reg_index, reg_en, tri_index, tri_en, din_out, ir_in, a_in,
           g_in, g_out, add_sub, done, illegal, busy, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/bus_control_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : bus_control_sequencer                                    |
// | Description : Fetches one instruction word and steps it through 1-3    |
// |               execute cycles, issuing register/tristate indices and    |
// |               ALU/DIN/IR controls for the shared-bus datapath.         |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module bus_control_sequencer #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  bus_control_sequencer_if.master bus
);

  localparam int c_INSTR_W = 3 + 2 * IDX_W;

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_T1   = 2'd1;
  localparam logic [1:0] c_S_T2   = 2'd2;
  localparam logic [1:0] c_S_T3   = 2'd3;

  localparam logic [2:0] c_OP_MV  = 3'b000;
  localparam logic [2:0] c_OP_MVI = 3'b001;
  localparam logic [2:0] c_OP_ADD = 3'b010;
  localparam logic [2:0] c_OP_SUB = 3'b011;

  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic [c_INSTR_W-1:0] r_ir;
  logic [CNT_W-1:0]     r_count;

  logic [2:0]       w_op;
  logic [IDX_W-1:0] w_rx;
  logic [IDX_W-1:0] w_ry;

  logic [IDX_W-1:0] w_reg_index;
  logic             w_reg_en;
  logic [IDX_W-1:0] w_tri_index;
  logic             w_tri_en;
  logic             w_din_out;
  logic             w_ir_in;
  logic             w_a_in;
  logic             w_g_in;
  logic             w_g_out;
  logic             w_add_sub;
  logic             w_done;
  logic             w_illegal;
  logic             w_busy;

  assign w_op = r_ir[c_INSTR_W-1 -: 3];
  assign w_rx = r_ir[2*IDX_W-1 -: IDX_W];
  assign w_ry = r_ir[IDX_W-1:0];

  // State register; a reset mid-instruction abandons it without retiring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_S_IDLE;
    else        r_state <= w_next;
  end

  // Instruction register loads only on the fetch edge, so it holds through T1-T3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_ir <= '0;
    else if (r_state == c_S_IDLE && bus.run)   r_ir <= bus.din;
  end

  // Retired-instruction counter: every done pulse counts, illegal ones too; wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_count <= '0;
    else if (w_done) r_count <= r_count + CNT_W'(1);
  end

  // Next-state: only add/sub need the extra T2/T3 cycles.
  always_comb begin
    w_next = c_S_IDLE;
    case (r_state)
      c_S_IDLE: w_next = bus.run ? c_S_T1 : c_S_IDLE;
      c_S_T1:   w_next = (w_op == c_OP_ADD || w_op == c_OP_SUB) ? c_S_T2 : c_S_IDLE;
      c_S_T2:   w_next = c_S_T3;
      default:  w_next = c_S_IDLE;
    endcase
  end

  // Control outputs decode state and IR; at most one bus driver per state.
  always_comb begin
    w_reg_index = '0;
    w_reg_en    = 1'b0;
    w_tri_index = '0;
    w_tri_en    = 1'b0;
    w_din_out   = 1'b0;
    w_ir_in     = 1'b0;
    w_a_in      = 1'b0;
    w_g_in      = 1'b0;
    w_g_out     = 1'b0;
    w_add_sub   = 1'b0;
    w_done      = 1'b0;
    w_illegal   = 1'b0;
    w_busy      = (r_state != c_S_IDLE);
    case (r_state)
      c_S_IDLE: w_ir_in = bus.run;
      c_S_T1: begin
        case (w_op)
          c_OP_MV: begin
            w_tri_en    = 1'b1;
            w_tri_index = w_ry;
            w_reg_en    = 1'b1;
            w_reg_index = w_rx;
            w_done      = 1'b1;
          end
          c_OP_MVI: begin
            w_din_out   = 1'b1;
            w_reg_en    = 1'b1;
            w_reg_index = w_rx;
            w_done      = 1'b1;
          end
          c_OP_ADD, c_OP_SUB: begin
            w_tri_en    = 1'b1;
            w_tri_index = w_rx;
            w_a_in      = 1'b1;
          end
          default: begin
            w_done    = 1'b1;
            w_illegal = 1'b1;
          end
        endcase
      end
      c_S_T2: begin
        w_tri_en    = 1'b1;
        w_tri_index = w_ry;
        w_g_in      = 1'b1;
        w_add_sub   = w_op[0];
      end
      default: begin
        w_g_out     = 1'b1;
        w_reg_en    = 1'b1;
        w_reg_index = w_rx;
        w_done      = 1'b1;
      end
    endcase
  end

  assign bus.reg_index   = w_reg_index;
  assign bus.reg_en      = w_reg_en;
  assign bus.tri_index   = w_tri_index;
  assign bus.tri_en      = w_tri_en;
  assign bus.din_out     = w_din_out;
  assign bus.ir_in       = w_ir_in;
  assign bus.a_in        = w_a_in;
  assign bus.g_in        = w_g_in;
  assign bus.g_out       = w_g_out;
  assign bus.add_sub     = w_add_sub;
  assign bus.done        = w_done;
  assign bus.illegal     = w_illegal;
  assign bus.busy        = w_busy;
  assign bus.instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bus_control_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_bus_control_sequencer                                 |
// | Description : Directed self-checking bench for bus_control_sequencer   |
// |               (IDX_W=4, CNT_W=4 so the counter wrap is reachable).     |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_bus_control_sequencer;

  localparam int c_IDX_W = 4;
  localparam int c_CNT_W = 4;

  // Flag bits of the packed control vector {din_out,ir_in,a_in,g_in,g_out,add_sub,done,illegal,busy}
  localparam logic [8:0] c_F_DIN  = 9'b1_0000_0000;
  localparam logic [8:0] c_F_IR   = 9'b0_1000_0000;
  localparam logic [8:0] c_F_A    = 9'b0_0100_0000;
  localparam logic [8:0] c_F_GIN  = 9'b0_0010_0000;
  localparam logic [8:0] c_F_GOUT = 9'b0_0001_0000;
  localparam logic [8:0] c_F_SUB  = 9'b0_0000_1000;
  localparam logic [8:0] c_F_DONE = 9'b0_0000_0100;
  localparam logic [8:0] c_F_ILL  = 9'b0_0000_0010;
  localparam logic [8:0] c_F_BUSY = 9'b0_0000_0001;

  logic clk;
  logic rst_n;
  int   r_checks;
  int   r_fails;

  bus_control_sequencer_if #(.IDX_W(c_IDX_W), .CNT_W(c_CNT_W)) bus ();

  bus_control_sequencer #(.IDX_W(c_IDX_W), .CNT_W(c_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  wire logic [18:0] w_obs = {bus.reg_index, bus.reg_en, bus.tri_index, bus.tri_en,
                             bus.din_out, bus.ir_in, bus.a_in, bus.g_in, bus.g_out,
                             bus.add_sub, bus.done, bus.illegal, bus.busy};
  wire logic [1:0]  w_drivers = 2'(bus.tri_en) + 2'(bus.din_out) + 2'(bus.g_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] ctl(input logic [3:0] ri, input logic re,
                                      input logic [3:0] ti, input logic te,
                                      input logic [8:0] flags);
    return {ri, re, ti, te, flags};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    r_checks++;
    if (got !== exp) begin
      r_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [10:0] r_b2b_din [8];
  logic [18:0] r_b2b_exp [8];
  logic [10:0] r_word;
  logic [3:0]  r_rx;
  logic [3:0]  r_ry;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    r_checks = 0;
    r_fails  = 0;
    rst_n    = 1'b0;
    bus.run  = 1'b0;
    bus.din  = '0;
    #1;
    chk("reset_ctl", 32'(w_obs), 32'd0);
    chk("reset_cnt", 32'(bus.instr_count), 32'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("idle_ctl", 32'(w_obs), 32'd0);

    // mv R3 <- R7
    bus.run = 1'b1;
    bus.din = {3'b000, 4'd3, 4'd7};
    #1 chk("mv_fetch", 32'(w_obs), 32'(ctl(0, 0, 0, 0, c_F_IR)));
    tick();
    bus.run = 1'b0;
    chk("mv_t1", 32'(w_obs), 32'(ctl(3, 1, 7, 1, c_F_DONE | c_F_BUSY)));
    tick();
    chk("mv_idle", 32'(w_obs), 32'd0);
    chk("mv_cnt", 32'(bus.instr_count), 32'd1);

    // sub R5 <- R5 - R2, with din garbage during execute
    bus.run = 1'b1;
    bus.din = {3'b011, 4'd5, 4'd2};
    tick();
    bus.run = 1'b0;
    bus.din = 11'h7FF;
    chk("sub_t1", 32'(w_obs), 32'(ctl(0, 0, 5, 1, c_F_A | c_F_BUSY)));
    tick();
    bus.din = 11'h123;
    chk("sub_t2", 32'(w_obs), 32'(ctl(0, 0, 2, 1, c_F_GIN | c_F_SUB | c_F_BUSY)));
    tick();
    chk("sub_t3", 32'(w_obs), 32'(ctl(5, 1, 0, 0, c_F_GOUT | c_F_DONE | c_F_BUSY)));
    tick();
    chk("sub_idle", 32'(w_obs), 32'd0);
    chk("sub_cnt", 32'(bus.instr_count), 32'd2);

    // run held high: mvi R1, add R2<-R2+R3, mv R4<-R5; done in cycles 2, 6, 8
    r_b2b_din[0] = {3'b001, 4'd1, 4'd0};  r_b2b_exp[0] = ctl(0, 0, 0, 0, c_F_IR);
    r_b2b_din[1] = 11'h7FF;               r_b2b_exp[1] = ctl(1, 1, 0, 0, c_F_DIN | c_F_DONE | c_F_BUSY);
    r_b2b_din[2] = {3'b010, 4'd2, 4'd3};  r_b2b_exp[2] = ctl(0, 0, 0, 0, c_F_IR);
    r_b2b_din[3] = 11'h5AA;               r_b2b_exp[3] = ctl(0, 0, 2, 1, c_F_A | c_F_BUSY);
    r_b2b_din[4] = 11'h4C1;               r_b2b_exp[4] = ctl(0, 0, 3, 1, c_F_GIN | c_F_BUSY);
    r_b2b_din[5] = 11'h6EE;               r_b2b_exp[5] = ctl(2, 1, 0, 0, c_F_GOUT | c_F_DONE | c_F_BUSY);
    r_b2b_din[6] = {3'b000, 4'd4, 4'd5};  r_b2b_exp[6] = ctl(0, 0, 0, 0, c_F_IR);
    r_b2b_din[7] = 11'h7FF;               r_b2b_exp[7] = ctl(4, 1, 5, 1, c_F_DONE | c_F_BUSY);
    bus.run = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.din = r_b2b_din[k];
      #1;
      chk($sformatf("b2b_c%0d", k + 1), 32'(w_obs), 32'(r_b2b_exp[k]));
      chk($sformatf("b2b_drv_c%0d", k + 1), 32'(w_drivers <= 2'd1), 32'd1);
      if (k == 7) bus.run = 1'b0;
      tick();
    end
    chk("b2b_cnt", 32'(bus.instr_count), 32'd5);

    // illegal opcode 101, then mv R1 <- R4
    bus.run = 1'b1;
    bus.din = {3'b101, 4'd2, 4'd9};
    tick();
    bus.run = 1'b0;
    chk("ill_t1", 32'(w_obs), 32'(ctl(0, 0, 0, 0, c_F_DONE | c_F_ILL | c_F_BUSY)));
    tick();
    bus.run = 1'b1;
    bus.din = {3'b000, 4'd1, 4'd4};
    tick();
    bus.run = 1'b0;
    chk("post_ill_mv", 32'(w_obs), 32'(ctl(1, 1, 4, 1, c_F_DONE | c_F_BUSY)));
    tick();
    chk("ill_cnt", 32'(bus.instr_count), 32'd7);

    // add R6 <- R6+R6 abandoned by reset during T2
    bus.run = 1'b1;
    bus.din = {3'b010, 4'd6, 4'd6};
    tick();
    bus.run = 1'b0;
    tick();
    chk("rst_pre_t2", 32'(w_obs), 32'(ctl(0, 0, 6, 1, c_F_GIN | c_F_BUSY)));
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", 32'(w_obs), 32'd0);
    chk("rst_async_cnt", 32'(bus.instr_count), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("rst_after_ctl", 32'(w_obs), 32'd0);
    chk("rst_after_cnt", 32'(bus.instr_count), 32'd0);

    // 17 mv instructions: 4-bit counter wraps 15 -> 0 and ends at 1
    for (int i = 0; i < 17; i++) begin
      r_rx   = 4'(i);
      r_ry   = 4'(15 - (i % 16));
      r_word = {3'b000, r_rx, r_ry};
      bus.run = 1'b1;
      bus.din = r_word;
      tick();
      bus.run = 1'b0;
      bus.din = ~r_word;
      #1;
      chk($sformatf("wrap_t1_%0d", i), 32'(w_obs), 32'(ctl(r_rx, 1, r_ry, 1, c_F_DONE | c_F_BUSY)));
      tick();
      chk($sformatf("wrap_cnt_%0d", i), 32'(bus.instr_count), 32'((i + 1) % 16));
    end
    chk("wrap_final", 32'(bus.instr_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", r_checks, r_fails);
    $finish;
  end

endmodule
`default_nettype wire
